// File: rtl/cpu16_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu16_pkg
//  Description : Shared encodings for the 16-bit multicycle CPU: opcodes,
//                ALU control codes, ALU-B and PC source selects, the 4-bit
//                controller state encoding and the control-word bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu16_pkg;

    // Opcodes (instr[15:12])
    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_addi = 4'b0100;
    localparam logic [3:0] c_op_lw   = 4'b0101;
    localparam logic [3:0] c_op_sw   = 4'b0110;
    localparam logic [3:0] c_op_beq  = 4'b0111;
    localparam logic [3:0] c_op_bc   = 4'b1000;
    localparam logic [3:0] c_op_jal  = 4'b1101;
    localparam logic [3:0] c_op_halt = 4'b1111;

    // ALU operations
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_breg   = 2'b00;
    localparam logic [1:0] c_srcb_two    = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // Controller state encoding (visible on the debug port)
    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_memadr = 4'd2;
    localparam logic [3:0] c_st_memrd  = 4'd3;
    localparam logic [3:0] c_st_memwb  = 4'd4;
    localparam logic [3:0] c_st_memwr  = 4'd5;
    localparam logic [3:0] c_st_exec_r = 4'd6;
    localparam logic [3:0] c_st_aluwb  = 4'd7;
    localparam logic [3:0] c_st_exec_i = 4'd8;
    localparam logic [3:0] c_st_branch = 4'd9;
    localparam logic [3:0] c_st_jump   = 4'd10;
    localparam logic [3:0] c_st_halt   = 4'd11;

    // One bundle of every datapath control, so the output decoder can
    // start from an all-zero default and only set what a state needs.
    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       memrd;
        logic       memwr;
    } ctrl_t;

    localparam ctrl_t c_ctrl_idle = '0;

endpackage : cpu16_pkg
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Combinational opcode classifier. Produces the R-type ALU
//                function and instruction-class flags used by the controller.
//  Ports       : i_op          opcode
//                o_alucontrol  ALU function for R-type (ADD otherwise)
//                o_is_*        instruction class flags
//                o_is_legal    opcode is defined
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decoder
    import cpu16_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [2:0] o_alucontrol,
    output logic       o_is_rtype,
    output logic       o_is_addi,
    output logic       o_is_mem,
    output logic       o_is_lw,
    output logic       o_is_branch,
    output logic       o_is_jal,
    output logic       o_is_halt,
    output logic       o_is_legal
);

    always_comb begin
        o_is_rtype  = (i_op == c_op_add) || (i_op == c_op_sub) ||
                      (i_op == c_op_and) || (i_op == c_op_or);
        o_is_addi   = (i_op == c_op_addi);
        o_is_lw     = (i_op == c_op_lw);
        o_is_mem    = (i_op == c_op_lw) || (i_op == c_op_sw);
        o_is_branch = (i_op == c_op_beq) || (i_op == c_op_bc);
        o_is_jal    = (i_op == c_op_jal);
        o_is_halt   = (i_op == c_op_halt);
        o_is_legal  = o_is_rtype || o_is_addi || o_is_mem || o_is_branch ||
                      o_is_jal || o_is_halt;
        // R-type opcodes carry the ALU function in their low bits
        o_alucontrol = o_is_rtype ? i_op[2:0] : c_alu_add;
    end

endmodule : alu_op_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Control FSM for the 16-bit multicycle CPU. Drives datapath
//                enables/selects and memory strobes, counts retired
//                instructions, flags illegal opcodes and memory timeouts.
//  Ports       : clk, reset (sync, active-high)
//                op, zero, carry, mem_ready           inputs
//                pcen..regdst, alusrcb, pcsrc,
//                alucontrol, memrd, memwr             datapath controls
//                state, retired, illegal, mem_timeout status
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
    import cpu16_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             carry,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             memrd,
    output logic             memwr,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             mem_timeout
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W:0] c_timeout_lim = TIMEOUT[WAIT_W:0];

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [CNT_W-1:0]  r_retired;
    logic              r_mem_timeout;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W:0]   w_wait_inc;
    logic              w_strobe;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_retire;
    logic              w_illegal;
    ctrl_t             w_ctrl;

    logic [2:0] w_rtype_alu;
    logic       w_is_rtype, w_is_addi, w_is_mem, w_is_lw;
    logic       w_is_branch, w_is_jal, w_is_halt, w_is_legal;

    alu_op_decoder u_dec (
        .i_op         (op),
        .o_alucontrol (w_rtype_alu),
        .o_is_rtype   (w_is_rtype),
        .o_is_addi    (w_is_addi),
        .o_is_mem     (w_is_mem),
        .o_is_lw      (w_is_lw),
        .o_is_branch  (w_is_branch),
        .o_is_jal     (w_is_jal),
        .o_is_halt    (w_is_halt),
        .o_is_legal   (w_is_legal)
    );

    // Memory wait tracking: only the strobe states can wait on mem_ready
    assign w_strobe   = (r_state == c_st_fetch) || (r_state == c_st_memrd) ||
                        (r_state == c_st_memwr);
    assign w_waiting  = w_strobe && !mem_ready;
    assign w_wait_inc = {1'b0, r_wait} + {{WAIT_W{1'b0}}, 1'b1};
    assign w_timeout  = (TIMEOUT != 0) && w_waiting && (w_wait_inc == c_timeout_lim);

    // ---------------- state register and counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_fetch;
            r_retired     <= '0;
            r_mem_timeout <= 1'b0;
            r_wait        <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_timeout)
                r_mem_timeout <= 1'b1;
            if (w_waiting && !w_timeout && (TIMEOUT != 0))
                r_wait <= w_wait_inc[WAIT_W-1:0];
            else
                r_wait <= '0;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            c_st_fetch:  if (mem_ready) w_next = c_st_decode;
            c_st_decode: begin
                if      (w_is_rtype)  w_next = c_st_exec_r;
                else if (w_is_addi)   w_next = c_st_exec_i;
                else if (w_is_mem)    w_next = c_st_memadr;
                else if (w_is_branch) w_next = c_st_branch;
                else if (w_is_jal)    w_next = c_st_jump;
                else if (w_is_halt)   w_next = c_st_halt;
                else begin
                    w_next    = c_st_fetch;
                    w_illegal = 1'b1;
                end
            end
            c_st_exec_r: w_next = c_st_aluwb;
            c_st_exec_i: w_next = c_st_aluwb;
            c_st_aluwb:  begin w_next = c_st_fetch; w_retire = 1'b1; end
            c_st_memadr: w_next = w_is_lw ? c_st_memrd : c_st_memwr;
            c_st_memrd:  if (mem_ready) w_next = c_st_memwb;
            c_st_memwb:  begin w_next = c_st_fetch; w_retire = 1'b1; end
            c_st_memwr:  if (mem_ready) begin w_next = c_st_fetch; w_retire = 1'b1; end
            c_st_branch: begin w_next = c_st_fetch; w_retire = 1'b1; end
            c_st_jump:   begin w_next = c_st_fetch; w_retire = 1'b1; end
            c_st_halt:   w_next = c_st_halt;
            default:     w_next = c_st_fetch;
        endcase
        // A memory overrun abandons whatever the strobe state wanted
        if (w_timeout)
            w_next = c_st_halt;
    end

    // ---------------- output decode ----------------
    always_comb begin
        w_ctrl = c_ctrl_idle;
        case (r_state)
            c_st_fetch: begin
                w_ctrl.memrd   = 1'b1;
                w_ctrl.alusrcb = c_srcb_two;
                w_ctrl.irwrite = mem_ready;
                w_ctrl.pcen    = mem_ready;
            end
            c_st_decode: w_ctrl.alusrcb = c_srcb_imm_sh;
            c_st_exec_r: begin
                w_ctrl.alusrca    = 1'b1;
                w_ctrl.alusrcb    = c_srcb_breg;
                w_ctrl.alucontrol = w_rtype_alu;
            end
            c_st_exec_i, c_st_memadr: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_srcb_imm;
            end
            c_st_aluwb: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = w_is_rtype;
            end
            c_st_memrd: begin
                w_ctrl.iord  = 1'b1;
                w_ctrl.memrd = 1'b1;
            end
            c_st_memwb: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            c_st_memwr: begin
                w_ctrl.iord  = 1'b1;
                w_ctrl.memwr = 1'b1;
            end
            c_st_branch: begin
                w_ctrl.alusrca    = 1'b1;
                w_ctrl.alusrcb    = c_srcb_breg;
                w_ctrl.alucontrol = c_alu_sub;
                w_ctrl.pcsrc      = c_pcsrc_aluout;
                // Mealy exception: the taken decision uses this cycle's flags
                w_ctrl.pcen       = ((op == c_op_beq) && zero) ||
                                    ((op == c_op_bc)  && carry);
            end
            c_st_jump: begin
                w_ctrl.pcsrc = c_pcsrc_jump;
                w_ctrl.pcen  = 1'b1;
            end
            default: w_ctrl = c_ctrl_idle;
        endcase
    end

    // Reset forces every output low, including the FETCH-state strobes
    assign pcen        = w_ctrl.pcen     & ~reset;
    assign irwrite     = w_ctrl.irwrite  & ~reset;
    assign regwrite    = w_ctrl.regwrite & ~reset;
    assign alusrca     = w_ctrl.alusrca  & ~reset;
    assign iord        = w_ctrl.iord     & ~reset;
    assign memtoreg    = w_ctrl.memtoreg & ~reset;
    assign regdst      = w_ctrl.regdst   & ~reset;
    assign alusrcb     = reset ? 2'b00 : w_ctrl.alusrcb;
    assign pcsrc       = reset ? 2'b00 : w_ctrl.pcsrc;
    assign alucontrol  = reset ? 3'b000 : w_ctrl.alucontrol;
    assign memrd       = w_ctrl.memrd    & ~reset;
    assign memwr       = w_ctrl.memwr    & ~reset;
    assign state       = reset ? c_st_fetch : r_state;
    assign retired     = reset ? '0 : r_retired;
    assign illegal     = w_illegal & ~reset;
    assign mem_timeout = r_mem_timeout & ~reset;

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller
//                (TIMEOUT=4 so the memory overrun path is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        zero, carry, mem_ready;
    logic        pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        memrd, memwr;
    logic [3:0]  state;
    logic [15:0] retired;
    logic        illegal, mem_timeout;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller #(.CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .carry(carry),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .memrd(memrd),
        .memwr(memwr), .state(state), .retired(retired),
        .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs may be changed afterwards, outputs settle by +1
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; op = 4'b0000; zero = 1'b0; carry = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        // 1: reset forces everything low
        check("rst_pcen",    {31'd0, pcen},    32'd0);
        check("rst_irwrite", {31'd0, irwrite}, 32'd0);
        check("rst_memrd",   {31'd0, memrd},   32'd0);
        check("rst_alusrcb", {30'd0, alusrcb}, 32'd0);
        check("rst_state",   {28'd0, state},   32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        reset = 1'b0; #1;
        check("f_pcen",    {31'd0, pcen},    32'd1);
        check("f_irwrite", {31'd0, irwrite}, 32'd1);
        check("f_memrd",   {31'd0, memrd},   32'd1);
        check("f_alusrcb", {30'd0, alusrcb}, 32'd1);

        // 2: ADD  states 0,1,6,7,0
        tick();
        check("add_s1",  {28'd0, state},   32'd1);
        check("dec_srcb",{30'd0, alusrcb}, 32'd3);
        tick();
        check("add_s6",  {28'd0, state},   32'd6);
        check("add_srca",{31'd0, alusrca}, 32'd1);
        tick();
        check("add_s7",  {28'd0, state},   32'd7);
        check("add_rw",  {31'd0, regwrite},32'd1);
        check("add_rd",  {31'd0, regdst},  32'd1);
        check("add_ret0",{16'd0, retired}, 32'd0);
        tick();
        check("add_s0",  {28'd0, state},   32'd0);
        check("add_ret1",{16'd0, retired}, 32'd1);

        // OR goes through EXEC_R with function 011
        op = 4'b0011;
        tick(); tick();
        check("or_alu",  {29'd0, alucontrol}, 32'd3);
        tick(); tick();
        check("or_ret",  {16'd0, retired}, 32'd2);

        // ADDI: regdst low in ALUWB
        op = 4'b0100;
        tick(); tick();
        check("addi_s8",  {28'd0, state},   32'd8);
        check("addi_srcb",{30'd0, alusrcb}, 32'd2);
        tick();
        check("addi_rd",  {31'd0, regdst},  32'd0);
        tick();
        check("addi_ret", {16'd0, retired}, 32'd3);

        // 3: LW with 3 wait cycles in MEMRD
        op = 4'b0101;
        tick(); tick();
        check("lw_s2", {28'd0, state}, 32'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_wait_s3",   {28'd0, state}, 32'd3);
            check("lw_wait_memrd",{31'd0, memrd}, 32'd1);
            check("lw_wait_iord", {31'd0, iord},  32'd1);
        end
        mem_ready = 1'b1; #1;
        check("lw_rdy_s3",    {28'd0, state}, 32'd3);
        check("lw_rdy_memrd", {31'd0, memrd}, 32'd1);
        tick();
        check("lw_s4",  {28'd0, state},    32'd4);
        check("lw_rw",  {31'd0, regwrite}, 32'd1);
        check("lw_m2r", {31'd0, memtoreg}, 32'd1);
        check("lw_rd",  {31'd0, regdst},   32'd0);
        tick();
        check("lw_ret", {16'd0, retired},  32'd4);

        // 4: BEQ taken/not-taken, BC taken
        op = 4'b0111; zero = 1'b1;
        tick(); tick();
        check("beq_s9",   {28'd0, state},      32'd9);
        check("beq_pcen", {31'd0, pcen},       32'd1);
        check("beq_pcsrc",{30'd0, pcsrc},      32'd1);
        check("beq_alu",  {29'd0, alucontrol}, 32'd1);
        zero = 1'b0; #1;
        check("beq_nt",   {31'd0, pcen},       32'd0);
        tick();
        check("beq_ret",  {16'd0, retired},    32'd5);
        op = 4'b1000; carry = 1'b1;
        tick(); tick();
        check("bc_pcen",  {31'd0, pcen},       32'd1);
        carry = 1'b0; zero = 1'b1; #1;
        check("bc_zero_only", {31'd0, pcen},   32'd0);
        zero = 1'b0;
        tick();

        // JAL
        op = 4'b1101;
        tick(); tick();
        check("jal_s10",  {28'd0, state}, 32'd10);
        check("jal_pcen", {31'd0, pcen},  32'd1);
        check("jal_pcsrc",{30'd0, pcsrc}, 32'd2);
        tick();
        check("jal_ret",  {16'd0, retired}, 32'd7);

        // 6: illegal opcode
        op = 4'b1010;
        tick();
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        tick();
        check("ill_s0",    {28'd0, state},   32'd0);
        check("ill_clr",   {31'd0, illegal}, 32'd0);
        check("ill_ret",   {16'd0, retired}, 32'd7);

        // SW zero-wait
        op = 4'b0110;
        tick(); tick(); tick();
        check("sw_s5",    {28'd0, state}, 32'd5);
        check("sw_memwr", {31'd0, memwr}, 32'd1);
        tick();
        check("sw_ret",   {16'd0, retired}, 32'd8);

        // Reset mid-instruction abandons it with no writes
        op = 4'b0000;
        tick(); tick(); tick();
        check("mid_s7", {28'd0, state}, 32'd7);
        reset = 1'b1; #1;
        check("mid_rw", {31'd0, regwrite}, 32'd0);
        tick();
        reset = 1'b0; #1;
        check("mid_s0",  {28'd0, state},   32'd0);
        check("mid_ret", {16'd0, retired}, 32'd0);

        // 5: FETCH memory timeout after 4 waiting cycles
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_s0", {28'd0, state},       32'd0);
            check("to_wait_mt", {31'd0, mem_timeout}, 32'd0);
        end
        check("to_last_memrd", {31'd0, memrd}, 32'd1);
        tick();
        check("to_s11",   {28'd0, state},       32'd11);
        check("to_flag",  {31'd0, mem_timeout}, 32'd1);
        check("to_memrd", {31'd0, memrd},       32'd0);
        mem_ready = 1'b1;
        tick(); tick();
        check("halt_hold", {28'd0, state},       32'd11);
        check("halt_pcen", {31'd0, pcen},        32'd0);
        check("halt_mt",   {31'd0, mem_timeout}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("rec_s0", {28'd0, state},       32'd0);
        check("rec_mt", {31'd0, mem_timeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule : tb_multicycle_controller
`default_nettype wire
